// File: rtl/adc_pkg.sv
// Shared definitions for the burst-accumulating ADC capture block.
// Holds the controller state type, the mode encoding and the helpers
// that derive the per-channel result width and the mean shift amount.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } adc_state_e;

  localparam logic MODE_MEAN = 1'b0;
  localparam logic MODE_SUM  = 1'b1;

  // Per-channel result width: wide enough that SAMPLES full-scale samples
  // can never overflow the accumulator.
  function automatic int calc_out_w(input int data_w, input int samples);
    return data_w + $clog2(samples);
  endfunction

  // Right shift that turns a burst sum into a mean (SAMPLES is a power of two).
  function automatic int calc_shift(input int samples);
    return $clog2(samples);
  endfunction

endpackage

// File: rtl/adc_burst_accum_if.sv
// Bus between the burst accumulator and its surroundings (trigger source,
// ADC front end and downstream consumer).
//   master : drives syncro_i, mode_i, adc_data_rdy_i, adc_data_i
//   slave  : the accumulator; drives adc_data_req_o, data_o, data_rdy_o,
//            timeout_o, sync_miss_o, busy_o
// Signal names keep the original port names of the capture block.
interface adc_burst_accum_if
  import adc_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int CHANNELS = 2,
  parameter int SAMPLES  = 8
);

  localparam int OUT_W = calc_out_w(DATA_W, SAMPLES);

  logic                      syncro_i;
  logic                      mode_i;
  logic                      adc_data_req_o;
  logic                      adc_data_rdy_i;
  logic [CHANNELS*DATA_W-1:0] adc_data_i;
  logic [CHANNELS*OUT_W-1:0]  data_o;
  logic                      data_rdy_o;
  logic                      timeout_o;
  logic                      sync_miss_o;
  logic                      busy_o;

  modport master (
    output syncro_i, mode_i, adc_data_rdy_i, adc_data_i,
    input  adc_data_req_o, data_o, data_rdy_o, timeout_o, sync_miss_o, busy_o
  );

  modport slave (
    input  syncro_i, mode_i, adc_data_rdy_i, adc_data_i,
    output adc_data_req_o, data_o, data_rdy_o, timeout_o, sync_miss_o, busy_o
  );

endinterface

// File: rtl/adc_chan_accum.sv
// One channel of the burst accumulator.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : zero the accumulator (burst start)
//   add_en    : add the sign-extended sample this cycle
//   sample    : signed DATA_W sample
//   mode      : MODE_MEAN or MODE_SUM
//   result    : mean or sum of the accumulator including this cycle's sample
module adc_chan_accum
  import adc_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int OUT_W  = 15,
  parameter int SHIFT  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     add_en,
  input  logic [DATA_W-1:0]        sample,
  input  logic                     mode,
  output logic signed [OUT_W-1:0]  result
);

  logic signed [OUT_W-1:0] acc_q;
  logic signed [OUT_W-1:0] acc_d;
  logic signed [OUT_W-1:0] sample_ext;

  assign sample_ext = {{(OUT_W-DATA_W){sample[DATA_W-1]}}, sample};

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + sample_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Result is taken from the next-state value so the top level can register
  // it on the same edge that accepts the final sample.
  assign result = (mode == MODE_SUM) ? acc_d : (acc_d >>> SHIFT);

endmodule

// File: rtl/adc_burst_accum.sv
// Sync-triggered multi-channel ADC burst accumulator.
// On a trigger it requests SAMPLES conversions, accumulates each channel as
// a signed value and publishes either the per-channel mean or raw sum.
// A run of TIMEOUT capture cycles without data aborts the burst; a trigger
// while busy is reported on sync_miss_o.
// Ports:
//   clk_i   : clock
//   reset_i : synchronous active-high reset
//   bus     : slave side of adc_burst_accum_if (trigger, ADC handshake,
//             results and status pulses)
module adc_burst_accum
  import adc_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int CHANNELS = 2,
  parameter int SAMPLES  = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  adc_burst_accum_if.slave   bus
);

  localparam int OUT_W = calc_out_w(DATA_W, SAMPLES);
  localparam int SHIFT = calc_shift(SAMPLES);
  localparam int CNT_W = $clog2(SAMPLES) + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(SAMPLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  adc_state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             mode_q;
  logic             acc_clr;
  logic             acc_add;
  logic             burst_end;
  logic             abort;
  logic             timeout_q;
  logic             miss_q;
  logic [CHANNELS*OUT_W-1:0] chan_result;
  logic [CHANNELS*OUT_W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    acc_clr   = 1'b0;
    acc_add   = 1'b0;
    burst_end = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.syncro_i) begin
          state_d = CAPTURE;
          acc_clr = 1'b1;
          cnt_d   = '0;
          to_d    = '0;
        end
      end
      CAPTURE: begin
        if (bus.adc_data_rdy_i) begin
          acc_add = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          to_d    = '0;
          if (cnt_q == LAST_SMP) begin
            state_d   = DONE;
            burst_end = 1'b1;
          end
        end else begin
          to_d = to_q + TO_W'(1);
          if (to_q == TO_LAST) begin
            state_d = IDLE;
            abort   = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      to_q      <= '0;
      mode_q    <= MODE_MEAN;
      timeout_q <= 1'b0;
      miss_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      timeout_q <= abort;
      miss_q    <= bus.syncro_i && (state_q != IDLE);
      if (state_q == IDLE && bus.syncro_i) begin
        mode_q <= bus.mode_i;
      end
      // Loaded on the edge that accepts the last sample so the result is
      // already valid during the single DONE cycle.
      if (burst_end) begin
        data_q <= chan_result;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    adc_chan_accum #(
      .DATA_W (DATA_W),
      .OUT_W  (OUT_W),
      .SHIFT  (SHIFT)
    ) u_accum (
      .clk    (clk_i),
      .rst    (reset_i),
      .clear  (acc_clr),
      .add_en (acc_add),
      .sample (bus.adc_data_i[c*DATA_W +: DATA_W]),
      .mode   (mode_q),
      .result (chan_result[c*OUT_W +: OUT_W])
    );
  end

  assign bus.adc_data_req_o = (state_q == CAPTURE);
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.data_rdy_o     = (state_q == DONE);
  assign bus.timeout_o      = timeout_q;
  assign bus.sync_miss_o    = miss_q;
  assign bus.data_o         = data_q;

endmodule

// File: tb/tb_adc_burst_accum.sv
// Self-checking bench for adc_burst_accum (DATA_W=12, CHANNELS=2,
// SAMPLES=8, TIMEOUT=64). Expected results come from a plain arithmetic
// model: sum the eight samples per channel, floor-divide by 8 for the mean.
module tb_adc_burst_accum;

  localparam int DW = 12;
  localparam int CH = 2;
  localparam int NS = 8;
  localparam int TO = 64;
  localparam int OW = 15;

  logic clk;
  logic rst;

  adc_burst_accum_if #(.DATA_W(DW), .CHANNELS(CH), .SAMPLES(NS)) bus ();

  adc_burst_accum #(
    .DATA_W   (DW),
    .CHANNELS (CH),
    .SAMPLES  (NS),
    .TIMEOUT  (TO)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_rdy = 0;
  int n_to  = 0;
  int n_miss = 0;

  int smp [CH][NS];
  logic [CH*OW-1:0] exp_data;

  always @(negedge clk) begin
    if (bus.data_rdy_o === 1'b1)  n_rdy++;
    if (bus.timeout_o === 1'b1)   n_to++;
    if (bus.sync_miss_o === 1'b1) n_miss++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int rand_sample();
    int v;
    v = int'($urandom_range(0, 4095));
    if (v > 2047) v -= 4096;
    return v;
  endfunction

  task automatic fill_random;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < NS; k++)
        smp[c][k] = rand_sample();
  endtask

  // Reference: per-channel sum; mean rounds toward minus infinity.
  function automatic logic [CH*OW-1:0] model_result(input bit m);
    logic [CH*OW-1:0] r;
    int s;
    int q;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      s = 0;
      for (int k = 0; k < NS; k++) s += smp[c][k];
      if (m) begin
        q = s;
      end else begin
        q = s / NS;
        if (s < 0 && (s % NS) != 0) q -= 1;
      end
      r[c*OW +: OW] = OW'(q);
    end
    return r;
  endfunction

  // Trigger, then send n samples from smp with the given gap (negative gap
  // means random 0..4). syncro_i is raised again with sample index miss_at.
  task automatic drive_burst(input bit m, input int gap, input int n, input int miss_at);
    bus.mode_i   = m;
    bus.syncro_i = 1'b1;
    tick();
    bus.syncro_i = 1'b0;
    bus.mode_i   = ~m;
    for (int k = 0; k < n; k++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 4)) : gap;
      bus.adc_data_rdy_i = 1'b0;
      for (int j = 0; j < g; j++) tick();
      bus.adc_data_rdy_i = 1'b1;
      bus.adc_data_i     = {12'(smp[1][k]), 12'(smp[0][k])};
      bus.syncro_i       = (k == miss_at);
      tick();
      bus.adc_data_rdy_i = 1'b0;
      bus.syncro_i       = 1'b0;
      bus.adc_data_i     = 24'($urandom);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    exp_data = '0;
    total++; if (bus.data_o !== exp_data) begin bad++; $display("FAIL reset_data: got %h want %h", bus.data_o, exp_data); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    total++; if (bus.adc_data_req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", bus.adc_data_req_o); end
    total++; if ({bus.data_rdy_o, bus.timeout_o, bus.sync_miss_o} !== 3'b000) begin bad++; $display("FAIL reset_pulses: got %b want 000", {bus.data_rdy_o, bus.timeout_o, bus.sync_miss_o}); end
    rst = 1'b0;
    bus.adc_data_rdy_i = 1'b1;
    bus.adc_data_i     = 24'h7ff7ff;
    tick();
    tick();
    bus.adc_data_rdy_i = 1'b0;
    total++; if (bus.busy_o !== 1'b0 || bus.data_rdy_o !== 1'b0) begin bad++; $display("FAIL idle_ignore_rdy: got busy=%b rdy=%b want 0 0", bus.busy_o, bus.data_rdy_o); end
  endtask

  task automatic test_mean;
    int base;
    for (int k = 0; k < NS; k++) begin
      smp[0][k] = 100;
      smp[1][k] = (k % 2 == 0) ? -2048 : 2047;
    end
    base = n_rdy;
    drive_burst(1'b0, 0, NS, -1);
    exp_data = model_result(1'b0);
    total++; if (bus.data_rdy_o !== 1'b1) begin bad++; $display("FAIL mean_rdy: got %b want 1", bus.data_rdy_o); end
    total++; if (bus.data_o !== exp_data) begin bad++; $display("FAIL mean_data: got %h want %h", bus.data_o, exp_data); end
    total++; if (bus.adc_data_req_o !== 1'b0) begin bad++; $display("FAIL mean_req_drop: got %b want 0", bus.adc_data_req_o); end
    // late data after the final sample must be ignored
    bus.adc_data_rdy_i = 1'b1;
    tick();
    tick();
    bus.adc_data_rdy_i = 1'b0;
    total++; if (bus.data_rdy_o !== 1'b0 || bus.busy_o !== 1'b0) begin bad++; $display("FAIL mean_after: got rdy=%b busy=%b want 0 0", bus.data_rdy_o, bus.busy_o); end
    total++; if (bus.data_o !== exp_data) begin bad++; $display("FAIL mean_hold: got %h want %h", bus.data_o, exp_data); end
    total++; if (n_rdy - base !== 1) begin bad++; $display("FAIL mean_rdy_count: got %0d want 1", n_rdy - base); end
  endtask

  task automatic test_sum_gaps;
    int base_to;
    for (int k = 0; k < NS; k++) begin
      smp[0][k] = -2048;
      smp[1][k] = 2047;
    end
    base_to = n_to;
    drive_burst(1'b1, 3, NS, -1);
    exp_data = model_result(1'b1);
    total++; if (bus.data_rdy_o !== 1'b1) begin bad++; $display("FAIL sum_rdy: got %b want 1", bus.data_rdy_o); end
    total++; if (bus.data_o !== exp_data) begin bad++; $display("FAIL sum_data: got %h want %h", bus.data_o, exp_data); end
    tick();
    total++; if (n_to - base_to !== 0) begin bad++; $display("FAIL sum_no_timeout: got %0d pulses want 0", n_to - base_to); end
  endtask

  task automatic test_timeout;
    int base_rdy;
    int base_to;
    int cyc;
    fill_random();
    base_rdy = n_rdy;
    base_to  = n_to;
    drive_burst(1'b0, 0, 3, -1);
    total++; if (bus.adc_data_req_o !== 1'b1 || bus.busy_o !== 1'b1) begin bad++; $display("FAIL capture_req_busy: got req=%b busy=%b want 1 1", bus.adc_data_req_o, bus.busy_o); end
    cyc = 0;
    for (int i = 1; i <= 2 * TO; i++) begin
      tick();
      if (bus.timeout_o === 1'b1) begin
        cyc = i;
        break;
      end
    end
    total++; if (cyc !== TO) begin bad++; $display("FAIL timeout_cycle: got %0d want %0d", cyc, TO); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL timeout_busy: got %b want 0", bus.busy_o); end
    total++; if (bus.data_o !== exp_data) begin bad++; $display("FAIL timeout_hold: got %h want %h", bus.data_o, exp_data); end
    tick();
    total++; if (bus.timeout_o !== 1'b0) begin bad++; $display("FAIL timeout_pulse_len: got %b want 0", bus.timeout_o); end
    total++; if (n_rdy - base_rdy !== 0 || n_to - base_to !== 1) begin bad++; $display("FAIL timeout_counts: got rdy=%0d to=%0d want 0 1", n_rdy - base_rdy, n_to - base_to); end
  endtask

  task automatic test_sync_miss;
    int base_rdy;
    int base_miss;
    fill_random();
    base_rdy  = n_rdy;
    base_miss = n_miss;
    drive_burst(1'b0, 1, NS, 4);
    exp_data = model_result(1'b0);
    total++; if (bus.data_o !== exp_data || bus.data_rdy_o !== 1'b1) begin bad++; $display("FAIL miss_data: got %h rdy=%b want %h 1", bus.data_o, bus.data_rdy_o, exp_data); end
    tick();
    tick();
    total++; if (n_miss - base_miss !== 1) begin bad++; $display("FAIL miss_count: got %0d want 1", n_miss - base_miss); end
    total++; if (n_rdy - base_rdy !== 1) begin bad++; $display("FAIL miss_rdy_count: got %0d want 1", n_rdy - base_rdy); end
  endtask

  task automatic test_reset_mid;
    int base_rdy;
    int base_to;
    fill_random();
    base_rdy = n_rdy;
    base_to  = n_to;
    drive_burst(1'b1, 0, 5, -1);
    rst = 1'b1;
    tick();
    exp_data = '0;
    total++; if (bus.data_o !== exp_data) begin bad++; $display("FAIL midrst_data: got %h want %h", bus.data_o, exp_data); end
    total++; if ({bus.busy_o, bus.adc_data_req_o, bus.data_rdy_o, bus.timeout_o, bus.sync_miss_o} !== 5'b0) begin bad++; $display("FAIL midrst_outputs: got %b want 00000", {bus.busy_o, bus.adc_data_req_o, bus.data_rdy_o, bus.timeout_o, bus.sync_miss_o}); end
    rst = 1'b0;
    tick();
    total++; if (n_rdy - base_rdy !== 0 || n_to - base_to !== 0) begin bad++; $display("FAIL midrst_pulses: got rdy=%0d to=%0d want 0 0", n_rdy - base_rdy, n_to - base_to); end
    fill_random();
    drive_burst(1'b1, -1, NS, -1);
    exp_data = model_result(1'b1);
    total++; if (bus.data_o !== exp_data || bus.data_rdy_o !== 1'b1) begin bad++; $display("FAIL midrst_burst: got %h rdy=%b want %h 1", bus.data_o, bus.data_rdy_o, exp_data); end
    tick();
  endtask

  task automatic test_back_to_back;
    int base_rdy;
    int base_miss;
    logic [CH*OW-1:0] exp_b;
    base_rdy  = n_rdy;
    base_miss = n_miss;
    fill_random();
    drive_burst(1'b0, 0, NS, -1);
    exp_data = model_result(1'b0);
    total++; if (bus.data_o !== exp_data || bus.data_rdy_o !== 1'b1) begin bad++; $display("FAIL b2b_first: got %h rdy=%b want %h 1", bus.data_o, bus.data_rdy_o, exp_data); end
    tick();
    fill_random();
    drive_burst(1'b1, 0, NS, -1);
    exp_b = model_result(1'b1);
    total++; if (bus.data_o !== exp_b || bus.data_rdy_o !== 1'b1) begin bad++; $display("FAIL b2b_second: got %h rdy=%b want %h 1", bus.data_o, bus.data_rdy_o, exp_b); end
    exp_data = exp_b;
    tick();
    total++; if (n_rdy - base_rdy !== 2 || n_miss - base_miss !== 0) begin bad++; $display("FAIL b2b_counts: got rdy=%0d miss=%0d want 2 0", n_rdy - base_rdy, n_miss - base_miss); end
  endtask

  task automatic test_random;
    bit m;
    for (int i = 0; i < 8; i++) begin
      fill_random();
      m = 1'($urandom_range(0, 1));
      drive_burst(m, -1, NS, -1);
      exp_data = model_result(m);
      total++; if (bus.data_o !== exp_data || bus.data_rdy_o !== 1'b1) begin bad++; $display("FAIL random_burst%0d: got %h rdy=%b want %h 1", i, bus.data_o, bus.data_rdy_o, exp_data); end
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) tick();
    end
  endtask

  initial begin
    rst                = 1'b1;
    bus.syncro_i       = 1'b0;
    bus.mode_i         = 1'b0;
    bus.adc_data_rdy_i = 1'b0;
    bus.adc_data_i     = '0;
    exp_data           = '0;
    test_reset();
    test_mean();
    test_sum_gaps();
    test_timeout();
    test_sync_miss();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_burst_accum.md
Name: adc_burst_accum

Overview:
Parametrised successor of the single-channel sync-triggered ADC capture block.
- On a `syncro_i` pulse it requests a burst of SAMPLES conversions from a multi-channel ADC and accumulates each channel as a signed value.
- It then presents either the per-channel mean or the raw sum, selected at trigger time.
- It adds a timeout abort and missed-sync reporting.
- It sits between the ADC interface and downstream sample processing, in the `clk_i` domain.

Parameters:
- DATA_W, 12, signed ADC sample width per channel.
- CHANNELS, 2, number of ADC channels packed on `adc_data_i`.
- SAMPLES, 8, samples per burst; power of two, at least 2.
- TIMEOUT, 64, maximum consecutive CAPTURE cycles without `adc_data_rdy_i` before abort.
- OUT_W (derived), DATA_W + $clog2(SAMPLES), per-channel output width.

Ports:
- `clk_i`, in, 1, system clock.
- `reset_i`, in, 1, synchronous active-high reset.
- `syncro_i`, in, 1, burst trigger; 1-cycle pulse.
- `mode_i`, in, 1, 0 = mean, 1 = raw sum; sampled on accepted trigger.
- `adc_data_req_o`, out, 1, request conversions from the ADC.
- `adc_data_rdy_i`, in, 1, sample valid this cycle.
- `adc_data_i`, in, CHANNELS*DATA_W, channel c in bits [c*DATA_W +: DATA_W], signed.
- `data_o`, out, CHANNELS*OUT_W, per-channel result, channel c in bits [c*OUT_W +: OUT_W], signed.
- `data_rdy_o`, out, 1, 1-cycle pulse, `data_o` valid.
- `timeout_o`, out, 1, 1-cycle pulse on burst abort.
- `sync_miss_o`, out, 1, 1-cycle pulse when `syncro_i` arrives while busy.
- `busy_o`, out, 1, high outside IDLE.

Behaviour:
- Clock and reset: one clock, `clk_i`. `reset_i` is synchronous and active-high.
- Reset values: state IDLE; all outputs 0, including `data_o`; accumulators, sample count and timeout count are 0.
- States: IDLE, CAPTURE, DONE.
- IDLE, no trigger: `adc_data_rdy_i` is ignored.
- IDLE, `syncro_i`=1:
  - latch `mode_i`, clear accumulators, sample count and timeout count;
  - go to CAPTURE.
  - `adc_data_req_o` and `busy_o` are 1 from the next cycle.
- CAPTURE: `adc_data_req_o`=1.
- CAPTURE, `adc_data_rdy_i`=1:
  - each channel sample is sign-extended to OUT_W and added to its accumulator;
  - sample count increments;
  - timeout count clears.
- CAPTURE, `adc_data_rdy_i`=0: timeout count increments.
- CAPTURE, last sample accepted (count reaches SAMPLES on that cycle): go to DONE; `adc_data_req_o` drops the next cycle.
- CAPTURE, timeout: when the timeout count reaches TIMEOUT, pulse `timeout_o` for 1 cycle, leave `data_o` unchanged, and return to IDLE. Partial sums are discarded.
- DONE (one cycle):
  - register `data_o`: mean is accumulator >>> $clog2(SAMPLES) (arithmetic shift, sign-extended to OUT_W); sum is the accumulator as-is;
  - `data_rdy_o`=1 for exactly that cycle;
  - return to IDLE.
- Latency: `data_rdy_o` and the new `data_o` are visible in the cycle after the last accepted sample.
- Holding: `data_o` holds its value until the next completed burst.
- Accumulator width: OUT_W, which cannot overflow. Extremes: -2048*8 = -16384 and 2047*8 = 16376 both fit in 15 bits.
- Trigger while busy: `syncro_i`=1 in CAPTURE or DONE is ignored for capture and pulses `sync_miss_o` in the next cycle.
- DONE then IDLE: a trigger arriving in the first IDLE cycle after DONE is accepted normally. There is no dead cycle beyond DONE.
- Late data: `adc_data_rdy_i` asserted after the final sample (in DONE or IDLE) is ignored.
- Reset mid-burst: abort immediately to reset values; no `data_rdy_o` or `timeout_o` pulse.

Decomposition:
- Package `adc_pkg` holds:
  - the state enum `adc_state_e` {IDLE, CAPTURE, DONE};
  - the localparam helpers for OUT_W and the shift amount;
  - the mode encoding constants MODE_MEAN=0, MODE_SUM=1.
- Sub-module `adc_chan_accum`, one instance per channel via generate:
  - inputs: clear, add-enable, sample, mode;
  - registered signed accumulator;
  - combinational mean/sum select.
- The top level owns the FSM, the counters and the output registers.

Test Plan:
All scenarios use DATA_W=12, CHANNELS=2, SAMPLES=8, TIMEOUT=64.
1. Mean mode, contiguous data: reset, `syncro_i` pulse, mode=0, 8 consecutive rdy cycles with ch0=100 and ch1 alternating -2048/2047 → `data_rdy_o` pulses 1 cycle after the 8th sample; ch0=100, ch1=-1; `adc_data_req_o` low the following cycle.
2. Sum mode with gaps: mode=1, ch0=-2048 ×8 with rdy gaps of 3 cycles → ch0=-16384, ch1 as driven (e.g. 2047 ×8 gives 16376); no timeout.
3. Timeout: trigger, 3 samples, then rdy held low for 64 cycles → `timeout_o` 1-cycle pulse, no `data_rdy_o`, `data_o` retains the previous burst value, `busy_o`=0.
4. Missed sync: `syncro_i` pulsed at sample 4 → `sync_miss_o` pulses once; the burst completes with the correct result; exactly one `data_rdy_o`.
5. Reset mid-burst: `reset_i` at sample 5 → all outputs 0 next cycle; a new trigger then yields the correct full-burst result.
6. Back-to-back bursts: trigger in the first IDLE cycle after DONE → second burst accepted; both `data_rdy_o` pulses present, with correct independent results.
